uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
16x-oversampling UART receiver. Consumes the divided UART clock from the clock generator (100 MHz / 54, about 16 x 115200) as a sample strobe, and deserialises the serial input into bytes. Offers each byte to the downstream sample/level logic through a valid/ready holding register. Uses a single clock domain; the divided clock is treated as data, never as a clock.

Parameters:
DATA_BITS, 8, data bits per frame, LSB first; no parity, 1 stop bit.
OVERSAMPLE, 16, os_clk rising edges per bit period; must be >= 8. Counter width is clog2(OVERSAMPLE).

Ports:
clk  in  1  system clock, 100 MHz.
rst  in  1  asynchronous, active-low reset.
os_clk  in  1  divided UART clock, any duty cycle; only its rising edge is used.
rx  in  1  serial line; idles high.
rx_ready  in  1  downstream accepts the byte this cycle.
rx_data  out  DATA_BITS  received byte.
rx_valid  out  1  rx_data holds an unaccepted byte.
frame_err  out  1  one-cycle pulse: stop bit sampled low.
overrun  out  1  one-cycle pulse: an unaccepted byte was overwritten.
busy  out  1  FSM state is not IDLE.

Behaviour:
- Reset (rst=0) applies immediately, mid-frame included:
  - FSM goes to IDLE; counters cleared.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - rx and os_clk synchroniser flops reset to 1.
- Input conditioning:
  - rx passes through 2 flops, giving rx_s.
  - os_clk passes through 2 sync flops plus 1 history flop.
  - tick = sync & ~history, i.e. a one-clk pulse per os_clk rising edge.
  - All FSM activity advances only on tick; between ticks all state holds.
- IDLE: on tick with rx_s=0, go to START with cnt=0.
- START: on each tick, cnt++.
  - At cnt==OVERSAMPLE/2-1 (mid start bit): if the sample is 0, go to DATA with cnt=0 and bit_idx=0.
  - Otherwise the start was a glitch: return to IDLE, with no output activity.
- DATA: on each tick, cnt++.
  - At cnt==OVERSAMPLE-1: shift the sample into the shift register (LSB first) and clear cnt.
  - If bit_idx==DATA_BITS-1, go to STOP; otherwise bit_idx++.
- STOP: at cnt==OVERSAMPLE-1, go to IDLE (mid stop bit; this gives the half-bit margin for the next start edge).
  - Sample 1: deliver the byte.
  - Sample 0: frame_err=1 for one clk, byte discarded.
  - Line held low (break): IDLE re-detects a start on the next tick; each break frame repeats frame_err.
- Delivery is in the clk cycle after the deciding tick:
  - rx_data is loaded and rx_valid is set.
  - Latency from the os_clk edge at mid stop bit to rx_valid: 5 clk (3 sync/edge stages, FSM, output register).
- Handshake:
  - rx_valid clears in the cycle after rx_valid & rx_ready.
  - rx_data is stable while rx_valid=1, unless overwritten.
- Delivery while rx_valid=1 and rx_ready=0: rx_data is overwritten, rx_valid stays 1, overrun pulses for one clk.
- Delivery in the same cycle as an accept (rx_valid & rx_ready): the new byte is loaded, rx_valid stays 1, no overrun.
- frame_err and overrun are never asserted together; a frame error never touches rx_data or rx_valid.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each decision (start, data, stop) is the 2-of-3 majority of rx_s at cnt==K-2, K-1 and K, where K is the decision count.
  - START: K = OVERSAMPLE/2-1.
  - DATA and STOP: K = OVERSAMPLE-1.
  - This rejects a single-tick glitch.
- Undefined: a single sample at cnt==K. No extra sample flops are instantiated.
- Timing is identical either way.

Test Plan:
- Bench: os_clk square wave, period 54 clk; frames driven at 16 os_clk periods per bit.
1. Frame 0xA5, stop=1, rx_ready held 1 -> rx_valid high exactly 1 clk, rx_data=0xA5, frame_err=0, overrun=0; busy returns to 0 by mid stop bit.
2. rx low for 3 os_clk periods then high -> no transition to DATA; busy falls at the mid-start check; rx_valid, frame_err and overrun stay 0.
3. Frame 0x3C with stop bit 0 -> frame_err one-cycle pulse, rx_valid stays 0; a following clean 0x3C frame is delivered normally.
4. Frames 0x11 then 0x22 with rx_ready=0 -> after the second frame rx_data=0x22, rx_valid=1, overrun pulses once; then rx_ready=1 for 1 clk -> rx_valid=0 the next cycle.
5. rst driven low during data bit 4 of a frame -> all outputs 0 immediately; after release, frame 0x5A -> rx_data=0x5A, no frame_err.
6. Frame 0xFF with a 1-os_clk low glitch centred on the mid-sample of bit 3 -> with UART_RX_MAJORITY_EN rx_data=0xFF; without it rx_data=0xF7.

Source files
------------

// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver with a valid/ready output holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on every bit decision.
module uart_rx_os #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_clk,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] K_START  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] K_BIT    = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    logic [1:0]           r_rx_sync;
    logic [1:0]           r_os_sync;
    logic                 r_os_hist;
    logic                 r_tick;
    logic                 w_rx_s;
    logic                 w_sample;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_done;
    logic                 r_ferr_p;

    // os_clk is treated as data: synchronise, then register its rising edge as a tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_sync <= 2'b11;
            r_os_sync <= 2'b11;
            r_os_hist <= 1'b1;
            r_tick    <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx};
            r_os_sync <= {r_os_sync[0], os_clk};
            r_os_hist <= r_os_sync[1];
            r_tick    <= r_os_sync[1] & ~r_os_hist;
        end
    end

    assign w_rx_s = r_rx_sync[1];

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] K_START_M1 = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] K_START_M2 = CW'(OVERSAMPLE / 2 - 3);
    localparam logic [CW-1:0] K_BIT_M1   = CW'(OVERSAMPLE - 2);
    localparam logic [CW-1:0] K_BIT_M2   = CW'(OVERSAMPLE - 3);

    logic [1:0]    r_smp;
    logic [CW-1:0] w_k_m1;
    logic [CW-1:0] w_k_m2;

    assign w_k_m1 = (r_state == StStart) ? K_START_M1 : K_BIT_M1;
    assign w_k_m2 = (r_state == StStart) ? K_START_M2 : K_BIT_M2;

    // Capture the two samples preceding each decision point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_smp <= 2'b11;
        end else if (r_tick) begin
            if (r_cnt == w_k_m2) r_smp[0] <= w_rx_s;
            if (r_cnt == w_k_m1) r_smp[1] <= w_rx_s;
        end
    end

    assign w_sample = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rx_s) | (r_smp[1] & w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_done    <= 1'b0;
            r_ferr_p  <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_ferr_p <= 1'b0;
            if (r_tick) begin
                case (r_state)
                    StIdle: begin
                        if (!w_rx_s) begin
                            r_state <= StStart;
                            r_cnt   <= '0;
                        end
                    end
                    StStart: begin
                        if (r_cnt == K_START) begin
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_state   <= w_sample ? StIdle : StData;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    StData: begin
                        if (r_cnt == K_BIT) begin
                            r_cnt   <= '0;
                            r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
                            if (r_bit_idx == LAST_BIT) begin
                                r_state <= StStop;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    StStop: begin
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        if (r_cnt == K_BIT) begin
                            r_cnt   <= '0;
                            r_state <= StIdle;
                            if (w_sample) begin
                                r_done <= 1'b1;
                            end else begin
                                r_ferr_p <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= r_ferr_p;
            overrun   <= 1'b0;
            if (r_done) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
                overrun  <= rx_valid & ~rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus randomized frames
// decoded by a per-os_clk-period line model.
module tb_uart_rx_os;

    logic       clk;
    logic       rst;
    logic       os_clk;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;
    int n_vcyc  = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int n_both  = 0;
    logic [7:0] acc_q[$];

    int b_acc, b_v, b_f, b_o;
    logic [152:0] ln;
    logic [8:0]   exp_r;

    uart_rx_os #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .os_clk    (os_clk),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 54-clk period, edges offset from clk edges
    initial begin
        os_clk = 1'b0;
        #2;
        forever begin
            os_clk = 1'b1;
            #270;
            os_clk = 1'b0;
            #270;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
            if (rx_valid) n_vcyc++;
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (frame_err && overrun) n_both++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_acc = acc_q.size();
        b_v   = n_vcyc;
        b_f   = n_ferr;
        b_o   = n_ovr;
    endtask

    // Line level for each os_clk period of a frame: start 0..15, data 16..143, stop 144..152.
    function automatic logic [152:0] mk_frame(input logic [7:0] d, input logic stop,
                                              input int gl);
        logic [152:0] l;
        for (int p = 0; p < 153; p++) begin
            if (p < 16) l[p] = 1'b0;
            else if (p < 144) l[p] = d[(p - 16) / 16];
            else l[p] = stop;
        end
        if (gl >= 0) l[gl] = ~l[gl];
        return l;
    endfunction

    function automatic logic samp(input logic [152:0] l, input int p);
`ifdef UART_RX_MAJORITY_EN
        int ones;
        ones = int'(l[p-2]) + int'(l[p-1]) + int'(l[p]);
        return (ones >= 2);
`else
        return l[p];
`endif
    endfunction

    // Receiver samples each bit at its middle period; returns {stop_sample, byte}.
    function automatic logic [8:0] decode(input logic [152:0] l);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = samp(l, 24 + 16 * i);
        return {samp(l, 152), b};
    endfunction

    task automatic send_line(input logic [152:0] l, input int n);
        for (int p = 0; p < n; p++) begin
            @(posedge os_clk);
            rx = l[p];
        end
    endtask

    task automatic send_frame(input logic [152:0] l);
        send_line(l, 153);
        @(posedge os_clk);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        logic       stop;
        int         gl;

        rst      = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge os_clk);

        // Clean frame, always ready
        snap();
        send_frame(mk_frame(8'hA5, 1'b1, -1));
        check("t1_nbytes", acc_q.size() - b_acc, 1);
        check("t1_data", acc_q[$], 8'hA5);
        check("t1_vcyc", n_vcyc - b_v, 1);
        check("t1_ferr", n_ferr - b_f, 0);
        check("t1_ovr", n_ovr - b_o, 0);
        check("t1_busy", busy, 1'b0);

        // Short low pulse is a false start
        snap();
        @(posedge os_clk);
        rx = 1'b0;
        repeat (2) @(posedge os_clk);
        @(posedge os_clk);
        rx = 1'b1;
        repeat (2) @(posedge os_clk);
        check("t2_busy_hi", busy, 1'b1);
        repeat (7) @(posedge os_clk);
        check("t2_busy_lo", busy, 1'b0);
        check("t2_vcyc", n_vcyc - b_v, 0);
        check("t2_ferr", n_ferr - b_f, 0);
        check("t2_ovr", n_ovr - b_o, 0);

        // Bad stop bit, then a clean frame
        snap();
        send_frame(mk_frame(8'h3C, 1'b0, -1));
        check("t3_ferr", n_ferr - b_f, 1);
        check("t3_vcyc", n_vcyc - b_v, 0);
        snap();
        send_frame(mk_frame(8'h3C, 1'b1, -1));
        check("t3_clean_n", acc_q.size() - b_acc, 1);
        check("t3_clean_data", acc_q[$], 8'h3C);
        check("t3_clean_ferr", n_ferr - b_f, 0);

        // Overrun with downstream stalled
        rx_ready = 1'b0;
        snap();
        send_frame(mk_frame(8'h11, 1'b1, -1));
        check("t4_first_valid", rx_valid, 1'b1);
        check("t4_first_data", rx_data, 8'h11);
        check("t4_first_ovr", n_ovr - b_o, 0);
        send_frame(mk_frame(8'h22, 1'b1, -1));
        check("t4_data", rx_data, 8'h22);
        check("t4_valid", rx_valid, 1'b1);
        check("t4_ovr", n_ovr - b_o, 1);
        check("t4_ferr", n_ferr - b_f, 0);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        check("t4_accept", rx_valid, 1'b0);
        rx_ready = 1'b1;

        // Asynchronous reset in the middle of data bit 4
        send_line(mk_frame(8'h96, 1'b1, -1), 88);
        repeat (10) @(posedge clk);
        #1;
        check("t5_busy_pre", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("t5_data", rx_data, 8'h00);
        check("t5_valid", rx_valid, 1'b0);
        check("t5_ferr", frame_err, 1'b0);
        check("t5_ovr", overrun, 1'b0);
        check("t5_busy", busy, 1'b0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b1;
        repeat (3) @(posedge os_clk);
        snap();
        send_frame(mk_frame(8'h5A, 1'b1, -1));
        check("t5_after_n", acc_q.size() - b_acc, 1);
        check("t5_after_data", acc_q[$], 8'h5A);
        check("t5_after_ferr", n_ferr - b_f, 0);

        // One-period glitch on the mid sample of bit 3
        snap();
        ln    = mk_frame(8'hFF, 1'b1, 72);
        exp_r = decode(ln);
        send_frame(ln);
        check("t6_n", acc_q.size() - b_acc, 1);
        check("t6_model", acc_q[$], exp_r[7:0]);
`ifdef UART_RX_MAJORITY_EN
        check("t6_data", acc_q[$], 8'hFF);
`else
        check("t6_data", acc_q[$], 8'hF7);
`endif

        // Randomized frames with glitches near the sample points
        for (int k = 0; k < 2; k++) begin
            d     = 8'($urandom);
            stop  = ($urandom_range(0, 3) != 0);
            gl    = 24 + 16 * int'($urandom_range(0, 7)) + int'($urandom_range(0, 2)) - 1;
            ln    = mk_frame(d, stop, gl);
            exp_r = decode(ln);
            snap();
            send_frame(ln);
            check("rnd_n", acc_q.size() - b_acc, {31'd0, exp_r[8]});
            check("rnd_ferr", n_ferr - b_f, {31'd0, ~exp_r[8]});
            if (exp_r[8]) check("rnd_data", acc_q[$], exp_r[7:0]);
        end

        check("never_both", n_both, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
